regfile_dump_ctrl: RTL
======================

// Module: regfile_dump_ctrl
//
// PURPOSE
// Sequences a full read-out of the register file over a shared read port and
// streams every register as bytes to the debug unit (UART TX side), x0..x31.
// Owns read port 1 while dumping; otherwise passes the CPU's address through.
// Sits between the ID stage, the regfile and the debug unit.
// Started by the debug unit only while the CPU is halted.
//
// PARAMETERS
// DATA_WIDTH  32  register width in bits; must be a multiple of 8
// NUM_REGS    32  registers dumped, index 0..NUM_REGS-1 (max 32)
//
// PORTS
// clk         in   1           clock, all logic on rising edge
// i_rst       in   1           synchronous reset, active-high
// i_start     in   1           dump request, sampled only in IDLE
// i_cpu_addr  in   5           CPU read address for regfile port 1
// o_rf_addr   out  5           address driven to regfile port 1
// i_rf_data   in   DATA_WIDTH  regfile port 1 data (combinational read)
// o_tx_data   out  8           byte to debug unit
// o_tx_valid  out  1           o_tx_data valid
// i_tx_ready  in   1           debug unit accepts byte this cycle
// o_busy      out  1           dump in progress (not IDLE)
// o_done      out  1           one-cycle pulse after last byte accepted
//
// BEHAVIOUR
// - BYTES = DATA_WIDTH/8; idx 5 bits, byte_cnt clog2(BYTES) bits, shreg DATA_WIDTH.
// - Reset: state=IDLE, idx=0, byte_cnt=0, shreg=0; o_tx_valid=0, o_tx_data=0,
//   o_busy=0, o_done=0, o_rf_addr=i_cpu_addr. Reset mid-dump aborts, no o_done.
// - o_rf_addr = (state==IDLE) ? i_cpu_addr : idx (combinational mux).
// - IDLE: i_start=1 -> LOAD, idx=0. i_start ignored in all other states.
// - LOAD (1 cycle): shreg <= i_rf_data, byte_cnt <= 0 -> SEND.
// - SEND: o_tx_valid=1, o_tx_data=shreg[7:0] (little-endian, LSB byte first).
//   Valid and data held stable until i_tx_ready=1. On accept:
//   byte_cnt<BYTES-1 -> shreg >>= 8, byte_cnt++, stay SEND;
//   byte_cnt==BYTES-1 and idx<NUM_REGS-1 -> idx++, LOAD;
//   byte_cnt==BYTES-1 and idx==NUM_REGS-1 -> DONE.
// - DONE (1 cycle): o_done=1, o_busy=1 -> IDLE.
// - i_tx_ready ignored outside SEND; no combinational path ready->valid.
// - Latency with ready held 1: start sampled edge 0; LOAD in cycle 1;
//   NUM_REGS*(1+BYTES) = 160 cycles of LOAD/SEND; o_done in cycle 161.
// - Regfile content is not modified; x0 streams as zero by regfile rule.
//
// TESTING
// 1 Regfile xN=0x11223300+N, ready=1, start pulse -> 128 bytes 00 33 22 11 is x0
//   as 00 00 00 00, x1 as 01 33 22 11 ... x31 1F 33 22 11; o_done in cycle 161.
// 2 Backpressure: ready low 3 cycles on every 2nd byte -> data/valid stable
//   while stalled, byte order unchanged, no byte lost or duplicated.
// 3 IDLE: i_cpu_addr sweeps 0..31 -> o_rf_addr equals it; o_busy=0, valid=0.
//   During dump o_rf_addr==idx regardless of i_cpu_addr.
// 4 i_start held high throughout dump -> exactly one dump; new dump starts
//   only in cycle after return to IDLE.
// 5 i_rst asserted while SEND at x7 byte 2 -> next cycle all outputs at reset
//   values, no o_done; subsequent start dumps from x0 byte 0.
// 6 Start with ready=0 permanently -> valid=1, o_tx_data=x0 byte0, state held.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer: walks x0..x(NUM_REGS-1) over regfile read port 1
// and streams each register LSB byte first to the debug unit with valid/ready.
//
// state | meaning
// IDLE  | port 1 follows the CPU address, waiting for i_start
// LOAD  | capture regfile word at idx into the shift register
// SEND  | offer shreg[7:0], shift on each accepted byte
// DONE  | one-cycle completion pulse, then back to IDLE
module regfile_dump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [4:0]            i_cpu_addr,
    output logic [4:0]            o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BYTES = DATA_WIDTH / 8;
    // Keep the byte counter at least one bit wide even for single-byte registers.
    localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [4:0]     LAST_IDX  = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [4:0]            idx_q,      idx_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,    shreg_d;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                shreg_d    = i_rf_data;
                byte_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (i_tx_ready) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        shreg_d    = shreg_q >> 8;
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end else if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so ready never reaches valid.
    always_comb begin
        o_rf_addr  = (state_q == IDLE) ? i_cpu_addr : idx_q;
        o_tx_valid = (state_q == SEND);
        o_tx_data  = (state_q == SEND) ? shreg_q[7:0] : 8'h00;
        o_busy     = (state_q != IDLE);
        o_done     = (state_q == DONE);
    end

endmodule
